packet_streamer: RTL and testbench

Frame serializer between the correlator core's packet register and the byte transport (UART TX or SPI slave). On a load pulse it snapshots the whole packet (header, payload, timestamp), then streams it MSB-first as bytes over a valid/ready handshake. Each frame ends with an 8-bit checksum, and in ASCII mode also a carriage return. A load that arrives while a frame is still in flight is dropped and counted, so a slow link never corrupts a frame.

---
 rtl/packet_streamer.sv | 87 ++++++++
 tb/tb_packet_streamer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/packet_streamer.sv
// packet_streamer: snapshots a packet on load and streams it as ASCII-hex or binary bytes with a checksum trailer.
module packet_streamer #(
  parameter int         PACKET_SIZE = 256,
  parameter bit         BINARY      = 1'b0,
  parameter logic [7:0] EOL         = 8'h0D
) (
  input  logic                   i_sysclk,
  input  logic                   i_reset,
  input  logic [PACKET_SIZE-1:0] i_packet,
  input  logic                   i_load,
  output logic                   o_busy,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_done,
  output logic                   o_overrun,
  output logic [7:0]             o_drop_count
);
  localparam int NCH = BINARY ? PACKET_SIZE / 8 : PACKET_SIZE / 4;
  localparam int IW = $clog2(NCH + 1);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  typedef enum logic [1:0] {IDLE, DATA, CSUM, TERM} state_t;
  state_t r_state, w_next;
  logic [PACKET_SIZE-1:0] r_shadow;
  logic [IW-1:0] r_idx;
  logic [7:0] r_csum, r_drop, w_byte;
  logic r_valid, r_done, r_overrun;
  logic w_accept, w_reject, w_xfer, w_end, w_csum_last, w_add;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
  // A load in the done cycle is still rejected, so the frame boundary is unambiguous.
  assign w_accept    = i_load & (r_state == IDLE) & ~r_done;
  assign w_reject    = i_load & ~w_accept;
  assign w_xfer      = r_valid & i_tx_ready;
  assign w_csum_last = BINARY | r_idx[0];
  assign w_end       = w_xfer & (w_next == IDLE);
  // In ASCII mode the byte is added on its high-nibble character, while both nibbles sit at the top.
  assign w_add       = (r_state == DATA) & (BINARY | ~r_idx[0]);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = DATA;
      DATA: if (w_xfer && r_idx == LAST) w_next = CSUM;
      CSUM: if (w_xfer && w_csum_last) w_next = BINARY ? IDLE : TERM;
      TERM: if (w_xfer) w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_sysclk) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_drop    <= 8'h00;
    end else begin
      r_done    <= w_end;
      r_overrun <= w_reject;
      if (w_reject && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_accept) begin
        r_shadow <= i_packet;
        r_idx    <= '0;
        r_csum   <= 8'h00;
        r_valid  <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= ~w_end;
        r_idx   <= (w_next != r_state) ? '0 : r_idx + IW'(1);
        if (r_state == DATA) r_shadow <= r_shadow << (BINARY ? 8 : 4);
        if (w_add) r_csum <= r_csum + r_shadow[PACKET_SIZE-1 -: 8];
      end
    end
  end
  always_comb begin
    w_byte = (r_state == DATA) ? (BINARY ? r_shadow[PACKET_SIZE-1 -: 8] : hex(r_shadow[PACKET_SIZE-1 -: 4])) :
             (r_state == CSUM) ? (BINARY ? r_csum : hex(r_idx[0] ? r_csum[3:0] : r_csum[7:4])) :
             (r_state == TERM) ? EOL : 8'h00;
  end
  assign o_busy       = r_state != IDLE;
  assign o_tx_byte    = w_byte;
  assign o_tx_valid   = r_valid;
  assign o_done       = r_done;
  assign o_overrun    = r_overrun;
  assign o_drop_count = r_drop;
endmodule

// File: tb/tb_packet_streamer.sv
// tb_packet_streamer: scoreboard bench for ASCII and binary packet_streamer instances at PACKET_SIZE=16.
module tb_packet_streamer;
  logic clk = 1'b0, rst = 1'b1, a_load = 1'b0, b_load = 1'b0, rdy = 1'b1;
  logic [15:0] pkt = 16'h0000;
  logic a_busy, a_valid, a_done, a_ovr, b_busy, b_valid, b_done, b_ovr;
  logic [7:0] a_byte, a_drop, b_byte, b_drop;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pb = 8'h00;
  int n_chk = 0, n_err = 0;
  logic [7:0] aq[$], bq[$];
  logic [7:0] hx [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                          8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  packet_streamer #(.PACKET_SIZE(16), .BINARY(1'b0), .EOL(8'h0D)) u_a (
    .i_sysclk(clk), .i_reset(rst), .i_packet(pkt), .i_load(a_load), .o_busy(a_busy),
    .o_tx_byte(a_byte), .o_tx_valid(a_valid), .i_tx_ready(rdy), .o_done(a_done),
    .o_overrun(a_ovr), .o_drop_count(a_drop));
  packet_streamer #(.PACKET_SIZE(16), .BINARY(1'b1), .EOL(8'h0D)) u_b (
    .i_sysclk(clk), .i_reset(rst), .i_packet(pkt), .i_load(b_load), .o_busy(b_busy),
    .o_tx_byte(b_byte), .o_tx_valid(b_valid), .i_tx_ready(rdy), .o_done(b_done),
    .o_overrun(b_ovr), .o_drop_count(b_drop));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_frame(input bit bin, input logic [15:0] p);
    logic [7:0] s;
    s = p[15:8] + p[7:0];
    if (bin) begin
      bq.push_back(p[15:8]); bq.push_back(p[7:0]); bq.push_back(s);
    end else begin
      aq.push_back(hx[p[15:12]]); aq.push_back(hx[p[11:8]]);
      aq.push_back(hx[p[7:4]]);   aq.push_back(hx[p[3:0]]);
      aq.push_back(hx[s[7:4]]);   aq.push_back(hx[s[3:0]]);
      aq.push_back(8'h0D);
    end
  endtask
  task automatic send(input bit bin, input logic [15:0] p);
    pkt = p;
    push_frame(bin, p);
    if (bin) b_load = 1'b1; else a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0; b_load = 1'b0;
  endtask
  task automatic wait_done(input bit bin, input int exp);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_after_load", bin ? b_busy : a_busy, 1);
        chk("valid_after_load", bin ? b_valid : a_valid, 1);
      end
      seen = bin ? b_done : a_done;
    end
    chk("done_seen", seen, 1);
    if (exp > 0) chk("frame_cycles", cyc, exp);
    chk("queue_empty", bin ? bq.size() : aq.size(), 0);
    chk("valid_in_done", bin ? b_valid : a_valid, 0);
    chk("busy_in_done", bin ? b_busy : a_busy, 0);
  endtask
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && a_valid && rdy) begin
      if (aq.size() == 0) chk("a_extra_byte", {24'h0, a_byte}, 32'h100);
      else begin e = aq.pop_front(); chk("a_byte", a_byte, e); end
    end
    if (!rst && b_valid && rdy) begin
      if (bq.size() == 0) chk("b_extra_byte", {24'h0, b_byte}, 32'h100);
      else begin e = bq.pop_front(); chk("b_byte", b_byte, e); end
    end
    if (!rst && pv && !pr) begin
      chk("a_hold_valid", a_valid, 1);
      chk("a_hold_byte", a_byte, pb);
    end
    pv <= a_valid;
    pr <= rdy;
    pb <= a_byte;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_byte", a_byte, 0);
    chk("rst_done", a_done, 0);
    chk("rst_overrun", a_ovr, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_b_valid", b_valid, 0);
    @(posedge clk); #1;
    send(0, 16'h12AB);
    wait_done(0, 8);
    @(posedge clk); #1;
    send(1, 16'h12AB);
    wait_done(1, 4);
    @(posedge clk); #1;
    send(0, 16'h12AB);
    @(posedge clk); @(posedge clk); #1;
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_byte", a_byte, 8'h41);
      chk("bp_valid", a_valid, 1);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done(0, 0);
    pkt = 16'h0F3C;
    a_load = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_reject_overrun", a_ovr, 1);
    chk("b2b_reject_busy", a_busy, 0);
    chk("b2b_drop", a_drop, 1);
    push_frame(0, 16'h0F3C);
    @(posedge clk); #1;
    a_load = 1'b0;
    wait_done(0, 8);
    @(posedge clk); #1;
    send(0, 16'h12AB);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    aq.delete();
    @(negedge clk);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_byte", a_byte, 0);
    chk("mid_rst_drop", a_drop, 0);
    send(0, 16'hFFFF);
    wait_done(0, 8);
    @(posedge clk); #1;
    rdy = 1'b0;
    send(0, 16'h12AB);
    for (int i = 0; i < 300; i++) begin
      pkt = 16'($urandom);
      a_load = 1'b1;
      @(posedge clk); #1;
      a_load = 1'b0;
      @(negedge clk);
      chk("ovr_pulse", a_ovr, 1);
      chk("ovr_drop", a_drop, (i + 1 > 255) ? 255 : i + 1);
      @(posedge clk); #1;
      chk("ovr_idle", a_ovr, 0);
    end
    rdy = 1'b1;
    wait_done(0, 0);
    chk("ovr_drop_final", a_drop, 255);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
